mux8_rr_arbiter: RTL and testbench

//  Round-robin arbiter sharing one 4-bit mux8x1_4b datapath among 8 requesters.

---
 rtl/mux8_rr_arbiter_pkg.sv | 18 +
 rtl/mux8x1_4b.sv | 32 +++
 rtl/rr_priority8.sv | 28 ++
 rtl/mux8_rr_arbiter.sv | 143 ++++++++++++++
 tb/tb_mux8_rr_arbiter.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared definitions for the 8-way round-robin mux arbiter: state encoding,
// bus geometry and the index-to-grant helper.
package mux8_rr_arbiter_pkg;

  localparam int NREQ  = 8;
  localparam int DW    = 4;
  localparam int SEL_W = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  function automatic logic [NREQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
    return NREQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux8x1_4b.sv
// Plain 8:1 multiplexer of 4-bit words, select given as discrete s2..s0 lines.
module mux8x1_4b
  import mux8_rr_arbiter_pkg::*;
(
  input  logic [DW-1:0] i0,
  input  logic [DW-1:0] i1,
  input  logic [DW-1:0] i2,
  input  logic [DW-1:0] i3,
  input  logic [DW-1:0] i4,
  input  logic [DW-1:0] i5,
  input  logic [DW-1:0] i6,
  input  logic [DW-1:0] i7,
  input  logic          s0,
  input  logic          s1,
  input  logic          s2,
  output logic [DW-1:0] f
);

  always_comb begin
    case ({s2, s1, s0})
      3'd0:    f = i0;
      3'd1:    f = i1;
      3'd2:    f = i2;
      3'd3:    f = i3;
      3'd4:    f = i4;
      3'd5:    f = i5;
      3'd6:    f = i6;
      default: f = i7;
    endcase
  end

endmodule

// File: rtl/rr_priority8.sv
// Rotating-priority encoder: returns the first asserted request found when
// scanning upward from ptr with wrap-around, plus a flag that any was found.
module rr_priority8
  import mux8_rr_arbiter_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] pick,
  output logic             any
);

  logic [SEL_W-1:0] scan_idx;

  // Scan from the lowest priority back to ptr so the last hit is the winner.
  always_comb begin
    pick     = '0;
    any      = 1'b0;
    scan_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      scan_idx = ptr + SEL_W'(k);
      if (req[scan_idx]) begin
        pick = scan_idx;
        any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter owning one shared 8:1 4-bit mux; holds a grant until the
// owner drops req or has moved MAX_HOLD beats while someone else is waiting.
module mux8_rr_arbiter
  import mux8_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [DW-1:0]   i0,
  input  logic [DW-1:0]   i1,
  input  logic [DW-1:0]   i2,
  input  logic [DW-1:0]   i3,
  input  logic [DW-1:0]   i4,
  input  logic [DW-1:0]   i5,
  input  logic [DW-1:0]   i6,
  input  logic [DW-1:0]   i7,
  input  logic            out_ready,
  output logic [NREQ-1:0] gnt,
  output logic            s0,
  output logic            s1,
  output logic            s2,
  output logic [DW-1:0]   f,
  output logic            out_valid,
  output logic            busy
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  arb_state_e       state, state_nxt;
  logic [NREQ-1:0]  gnt_nxt;
  logic [SEL_W-1:0] sel, sel_nxt;
  logic [SEL_W-1:0] ptr, ptr_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic [NREQ-1:0]  arb_req;
  logic [SEL_W-1:0] arb_ptr;
  logic [SEL_W-1:0] pick;
  logic             any;
  logic             xfer;
  logic             others_wait;
  logic             release_now;

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    if (c == HOLD_LAST) return c;
    return c + 1'b1;
  endfunction

  // While granted, the arbiter only ever looks at the next owner: exclude the
  // current one and start the scan just past it.
  assign arb_req = (state == ST_GRANT) ? (req & ~gnt) : req;
  assign arb_ptr = (state == ST_GRANT) ? (sel + 3'd1) : ptr;

  rr_priority8 u_prio (
    .req  (arb_req),
    .ptr  (arb_ptr),
    .pick (pick),
    .any  (any)
  );

  assign xfer        = out_valid & out_ready;
  assign others_wait = |(req & ~gnt);
  assign release_now = ~req[sel] | (xfer & (cnt == HOLD_LAST) & others_wait);

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      gnt   <= '0;
      sel   <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      sel   <= sel_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // ---- next-state logic ----
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    sel_nxt   = sel;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (any) begin
          state_nxt = ST_GRANT;
          gnt_nxt   = idx_to_onehot(pick);
          sel_nxt   = pick;
          cnt_nxt   = '0;
        end
      end
      default: begin
        if (release_now) begin
          ptr_nxt = arb_ptr;
          cnt_nxt = '0;
          if (any) begin
            state_nxt = ST_GRANT;
            gnt_nxt   = idx_to_onehot(pick);
            sel_nxt   = pick;
          end else begin
            state_nxt = ST_IDLE;
            gnt_nxt   = '0;
          end
        end else if (xfer) begin
          cnt_nxt = cnt_sat_inc(cnt);
        end
      end
    endcase
  end

  // ---- outputs ----
  always_comb begin
    busy      = (state == ST_GRANT);
    out_valid = busy & req[sel];
    s0        = sel[0];
    s1        = sel[1];
    s2        = sel[2];
  end

  mux8x1_4b u_mux (
    .i0 (i0),
    .i1 (i1),
    .i2 (i2),
    .i3 (i3),
    .i4 (i4),
    .i5 (i5),
    .i6 (i6),
    .i7 (i7),
    .s0 (s0),
    .s1 (s1),
    .s2 (s2),
    .f  (f)
  );

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Randomized and directed bench for mux8_rr_arbiter; two instances (MAX_HOLD 8
// and 2) share stimulus and are each tracked by an integer-level owner model.
module tb_mux8_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic [3:0] din [8];
  logic       out_ready;

  logic [7:0] gnt_w   [2];
  logic       s0_w    [2];
  logic       s1_w    [2];
  logic       s2_w    [2];
  logic [3:0] f_w     [2];
  logic       valid_w [2];
  logic       busy_w  [2];

  int nvec = 0;
  int nerr = 0;

  int m_own [2];
  int m_sel [2];
  int m_ptr [2];
  int m_cnt [2];
  int m_max [2] = '{8, 2};

  always #5 clk = ~clk;

  mux8_rr_arbiter #(.MAX_HOLD(8), .CNT_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req),
    .i0(din[0]), .i1(din[1]), .i2(din[2]), .i3(din[3]),
    .i4(din[4]), .i5(din[5]), .i6(din[6]), .i7(din[7]),
    .out_ready(out_ready), .gnt(gnt_w[0]),
    .s0(s0_w[0]), .s1(s1_w[0]), .s2(s2_w[0]), .f(f_w[0]),
    .out_valid(valid_w[0]), .busy(busy_w[0])
  );

  mux8_rr_arbiter #(.MAX_HOLD(2), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req),
    .i0(din[0]), .i1(din[1]), .i2(din[2]), .i3(din[3]),
    .i4(din[4]), .i5(din[5]), .i6(din[6]), .i7(din[7]),
    .out_ready(out_ready), .gnt(gnt_w[1]),
    .s0(s0_w[1]), .s1(s1_w[1]), .s2(s2_w[1]), .f(f_w[1]),
    .out_valid(valid_w[1]), .busy(busy_w[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++)
      if (r[(p + k) % 8]) return (p + k) % 8;
    return -1;
  endfunction

  function automatic logic [7:0] own_mask(input int o);
    return (o >= 0) ? (8'h01 << o) : 8'h00;
  endfunction

  task automatic model_reset(input int d);
    m_own[d] = -1; m_sel[d] = 0; m_ptr[d] = 0; m_cnt[d] = 0;
  endtask

  // Advance the owner model by one clock edge using the inputs held across it.
  task automatic model_edge(input int d);
    bit xfer, waiting, rel;
    int p;
    if (!rst_n) begin
      model_reset(d);
    end else if (m_own[d] < 0) begin
      p = rr_pick(req, m_ptr[d]);
      if (p >= 0) begin
        m_own[d] = p; m_sel[d] = p; m_cnt[d] = 0;
      end
    end else begin
      xfer    = req[m_own[d]] && out_ready;
      waiting = (req & ~own_mask(m_own[d])) != 8'h00;
      rel     = !req[m_own[d]] || (xfer && m_cnt[d] == m_max[d] - 1 && waiting);
      if (rel) begin
        m_ptr[d] = (m_own[d] + 1) % 8;
        m_cnt[d] = 0;
        p = rr_pick(req & ~own_mask(m_own[d]), m_ptr[d]);
        m_own[d] = p;
        if (p >= 0) m_sel[d] = p;
      end else if (xfer && m_cnt[d] < m_max[d] - 1) begin
        m_cnt[d]++;
      end
    end
  endtask

  task automatic check_outputs();
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("gnt%0d", d), 32'(gnt_w[d]), 32'(own_mask(m_own[d])));
      check_eq($sformatf("sel%0d", d), 32'({s2_w[d], s1_w[d], s0_w[d]}), 32'(m_sel[d]));
      check_eq($sformatf("busy%0d", d), 32'(busy_w[d]), 32'(m_own[d] >= 0));
      check_eq($sformatf("valid%0d", d), 32'(valid_w[d]),
               32'((m_own[d] >= 0) && req[m_own[d]]));
      check_eq($sformatf("f%0d", d), 32'(f_w[d]), 32'(din[m_sel[d]]));
    end
  endtask

  // Called at a negedge with inputs already set; returns at the next negedge.
  task automatic step();
    #1;
    check_outputs();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req = 8'hFF;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) din[k] = 4'(k + 3);
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset(0);
    model_reset(1);

    // Reset with every request high.
    step();
    check_eq("t1_gnt", 32'(gnt_w[0]), 32'h00);
    check_eq("t1_sel", 32'({s2_w[0], s1_w[0], s0_w[0]}), 32'h0);
    check_eq("t1_valid", 32'(valid_w[0]), 32'h0);
    check_eq("t1_busy", 32'(busy_w[0]), 32'h0);

    // Single requester 5.
    rst_n = 1'b1; req = 8'h20; din[5] = 4'hA; out_ready = 1'b1;
    step();
    check_eq("t2_gnt", 32'(gnt_w[0]), 32'h20);
    check_eq("t2_sel", 32'({s2_w[0], s1_w[0], s0_w[0]}), 32'h5);
    check_eq("t2_f", 32'(f_w[0]), 32'hA);
    check_eq("t2_valid", 32'(valid_w[0]), 32'h1);
    req = 8'h00;
    step();
    check_eq("t2_release", 32'(gnt_w[0]), 32'h00);

    // Two requesters alternate in 8-beat slices.
    do_reset();
    req = 8'h81; out_ready = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin check_eq("t3_own0", 32'(gnt_w[0]), 32'h01); step(); end
    for (int i = 0; i < 8; i++) begin check_eq("t3_own7", 32'(gnt_w[0]), 32'h80); step(); end
    check_eq("t3_back0", 32'(gnt_w[0]), 32'h01);

    // Stalled sink never preempts.
    do_reset();
    req = 8'h03; out_ready = 1'b0;
    step();
    for (int i = 0; i < 20; i++) begin check_eq("t4_hold", 32'(gnt_w[0]), 32'h01); step(); end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin check_eq("t4_beats", 32'(gnt_w[0]), 32'h01); step(); end
    check_eq("t4_switch", 32'(gnt_w[0]), 32'h02);

    // All requesting, MAX_HOLD=2 instance rotates every two beats.
    do_reset();
    req = 8'hFF; out_ready = 1'b1;
    step();
    for (int o = 0; o < 9; o++)
      for (int b = 0; b < 2; b++) begin
        check_eq("t5_rot", 32'(gnt_w[1]), 32'(8'h01 << (o % 8)));
        check_eq("t5_busy", 32'(busy_w[1]), 32'h1);
        step();
      end

    // Reset mid-grant restarts the pointer.
    do_reset();
    req = 8'h10;
    repeat (3) step();
    check_eq("t6_own4", 32'(gnt_w[0]), 32'h10);
    rst_n = 1'b0;
    step();
    check_eq("t6_rst", 32'(gnt_w[0]), 32'h00);
    rst_n = 1'b1; req = 8'hFF;
    step();
    check_eq("t6_ptr0", 32'(gnt_w[0]), 32'h01);

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 3) == 0) req = req ^ 8'($urandom);
      if ($urandom_range(0, 15) == 0) req = 8'h00;
      out_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 8; k++) din[k] = 4'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
